// File: rtl/noise_gate_pkg.sv
// -----------------------------------------------------------------------------
// noise_gate_pkg
// Shared definitions for the guitar-chain noise gate: datapath widths, gain
// ramp constants, the gate FSM state encoding and the close-threshold helper.
// -----------------------------------------------------------------------------
package noise_gate_pkg;

  localparam int FXP_SIZE  = 16;  // sample width, signed two's complement
  localparam int GAIN_BITS = 8;   // gain fraction bits
  localparam int GAIN_W    = GAIN_BITS + 1;  // gain spans 0..256 inclusive
  localparam int ENV_SHIFT = 6;   // envelope decay shift
  localparam int HOLD_BITS = 12;  // hold-length width

  localparam logic [GAIN_W-1:0] GAIN_ONE     = GAIN_W'(1 << GAIN_BITS);
  localparam logic [GAIN_W-1:0] ATTACK_STEP  = GAIN_W'(16);
  localparam logic [GAIN_W-1:0] RELEASE_STEP = GAIN_W'(1);

  typedef enum logic [2:0] {
    ST_CLOSED  = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_OPEN    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } gate_state_t;

  // Close level sits 25 % below the open threshold so the gate does not
  // chatter when the envelope hovers around a single level.
  function automatic logic [FXP_SIZE-1:0] close_level(input logic [FXP_SIZE-1:0] thr);
    return thr - (thr >> 2);
  endfunction

endpackage

// File: rtl/gate_env_follower.sv
// -----------------------------------------------------------------------------
// gate_env_follower
// Stage 1 of the noise gate: registers the incoming sample and tracks a peak
// envelope of its magnitude (instant attack, exponential decay per sample).
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_valid       input sample strobe
//   i_sample      signed input sample
//   o_valid       registered strobe (stage-1 valid)
//   o_sample      registered sample
//   o_env         envelope after this sample's update (unsigned)
// -----------------------------------------------------------------------------
module gate_env_follower
  import noise_gate_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  input  logic signed [FXP_SIZE-1:0] i_sample,
  output logic                       o_valid,
  output logic signed [FXP_SIZE-1:0] o_sample,
  output logic        [FXP_SIZE-1:0] o_env
);

  localparam logic signed [FXP_SIZE-1:0] S_MIN   = {1'b1, {(FXP_SIZE-1){1'b0}}};
  localparam logic        [FXP_SIZE-1:0] MAG_MAX = {1'b0, {(FXP_SIZE-1){1'b1}}};

  logic        [FXP_SIZE-1:0] mag;
  logic        [FXP_SIZE-1:0] env_d,    env_q;
  logic signed [FXP_SIZE-1:0] sample_d, sample_q;
  logic                       valid_d,  valid_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    // The most negative sample has no positive twin; saturate its magnitude.
    if (i_sample == S_MIN) begin
      mag = MAG_MAX;
    end else if (i_sample[FXP_SIZE-1]) begin
      mag = -i_sample;
    end else begin
      mag = i_sample;
    end

    env_d    = env_q;
    sample_d = sample_q;
    valid_d  = i_valid;

    // Decay is applied per sample, so idle cycles leave the envelope alone.
    if (i_valid) begin
      sample_d = i_sample;
      env_d    = (mag > env_q) ? mag : env_q - (env_q >> ENV_SHIFT);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      env_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      env_q    <= env_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_sample = sample_q;
  assign o_env    = env_q;

endmodule

// File: rtl/noise_gate.sv
// -----------------------------------------------------------------------------
// noise_gate
// Upstream noise gate feeding the overdrive sample input. Stage 1 (envelope
// follower) registers the sample and envelope; stage 2 runs the
// CLOSED/ATTACK/OPEN/HOLD/RELEASE FSM, ramps the gain and registers the gated
// sample. Latency is two cycles, one sample per cycle, no backpressure.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_valid       input sample strobe
//   i_sample      signed input sample
//   i_threshold   unsigned open threshold (magnitude)
//   i_hold        hold length in samples
//   i_bypass      1 = pass the sample ungated (FSM keeps running)
//   o_valid       output strobe
//   o_sample      signed gated sample
//   o_state       current FSM state (debug)
// -----------------------------------------------------------------------------
module noise_gate
  import noise_gate_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  input  logic signed [FXP_SIZE-1:0]  i_sample,
  input  logic        [FXP_SIZE-1:0]  i_threshold,
  input  logic        [HOLD_BITS-1:0] i_hold,
  input  logic                        i_bypass,
  output logic                        o_valid,
  output logic signed [FXP_SIZE-1:0]  o_sample,
  output logic        [2:0]           o_state
);

  logic                       s1_valid;
  logic signed [FXP_SIZE-1:0] s1_sample;
  logic        [FXP_SIZE-1:0] env;

  gate_env_follower u_env (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .i_sample (i_sample),
    .o_valid  (s1_valid),
    .o_sample (s1_sample),
    .o_env    (env)
  );

  gate_state_t                state_d,    state_q;
  logic        [GAIN_W-1:0]   g_d,        g_q;
  logic        [HOLD_BITS-1:0] hold_cnt_d, hold_cnt_q;
  logic                       o_valid_d,  o_valid_q;
  logic signed [FXP_SIZE-1:0] o_sample_d, o_sample_q;

  logic                            is_open;
  logic                            is_close;
  logic        [GAIN_W:0]          g_up;
  logic signed [FXP_SIZE+GAIN_W:0] product;

  always_comb begin
    is_open  = (env >= i_threshold);
    is_close = (env < close_level(i_threshold));
    g_up     = {1'b0, g_q} + {1'b0, ATTACK_STEP};
    // Gain is unsigned; a zero sign bit keeps the multiply signed x positive.
    product  = s1_sample * $signed({1'b0, g_q});

    state_d    = state_q;
    g_d        = g_q;
    hold_cnt_d = hold_cnt_q;
    o_valid_d  = s1_valid;
    o_sample_d = o_sample_q;

    if (s1_valid) begin
      // Output uses the gain from before this sample's FSM update. Taking the
      // slice above GAIN_BITS is an arithmetic shift, rounding toward -inf.
      o_sample_d = i_bypass ? s1_sample : product[GAIN_BITS +: FXP_SIZE];

      // Between the close and open levels every state simply holds.
      unique case (state_q)
        ST_CLOSED: begin
          if (is_open) state_d = ST_ATTACK;
        end
        ST_ATTACK: begin
          if (g_up >= {1'b0, GAIN_ONE}) begin
            g_d     = GAIN_ONE;
            state_d = ST_OPEN;
          end else begin
            g_d = g_up[GAIN_W-1:0];
          end
        end
        ST_OPEN: begin
          if (is_close) begin
            state_d    = ST_HOLD;
            hold_cnt_d = i_hold;
          end
        end
        ST_HOLD: begin
          if (is_open) begin
            state_d = ST_OPEN;
          end else if (hold_cnt_q == '0) begin
            state_d = ST_RELEASE;
          end else begin
            hold_cnt_d = hold_cnt_q - HOLD_BITS'(1);
          end
        end
        ST_RELEASE: begin
          if (is_open) begin
            state_d = ST_ATTACK;  // ramp resumes from the current gain
          end else if (g_q <= RELEASE_STEP) begin
            g_d     = '0;
            state_d = ST_CLOSED;
          end else begin
            g_d = g_q - RELEASE_STEP;
          end
        end
        default: begin
          state_d = ST_CLOSED;
          g_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLOSED;
      g_q        <= '0;
      hold_cnt_q <= '0;
      o_valid_q  <= 1'b0;
      o_sample_q <= '0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      hold_cnt_q <= hold_cnt_d;
      o_valid_q  <= o_valid_d;
      o_sample_q <= o_sample_d;
    end
  end

  assign o_valid  = o_valid_q;
  assign o_sample = o_sample_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_noise_gate.sv
// -----------------------------------------------------------------------------
// tb_noise_gate
// Directed bench for noise_gate. Each sample is sent with its hand-derived
// expected output and state; a negedge monitor collects what the DUT emits
// and drain() compares the two streams in order.
// -----------------------------------------------------------------------------
module tb_noise_gate;

  localparam int CLOSED  = 0;
  localparam int ATTACK  = 1;
  localparam int OPEN    = 2;
  localparam int HOLD    = 3;
  localparam int RELEASE = 4;

  logic               clk;
  logic               rst;
  logic               i_valid;
  logic signed [15:0] i_sample;
  logic        [15:0] i_threshold;
  logic        [11:0] i_hold;
  logic               i_bypass;
  logic               o_valid;
  logic signed [15:0] o_sample;
  logic        [2:0]  o_state;

  noise_gate dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_sample    (i_sample),
    .i_threshold (i_threshold),
    .i_hold      (i_hold),
    .i_bypass    (i_bypass),
    .o_valid     (o_valid),
    .o_sample    (o_sample),
    .o_state     (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int got_s[$];
  int got_st[$];
  int exp_s[$];
  int exp_st[$];
  int env_m = 0;  // bench-side envelope, used only to know when the gate closes

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int env_next(input int env, input int s);
    int m;
    m = (s < 0) ? -s : s;
    if (m > 32767) m = 32767;
    return (m > env) ? m : env - (env >> 6);
  endfunction

  always @(negedge clk) begin
    if (o_valid) begin
      got_s.push_back(int'(o_sample));
      got_st.push_back(int'(o_state));
    end
  end

  task automatic send(input int s, input int es, input int est);
    i_sample = 16'(s);
    i_valid  = 1'b1;
    exp_s.push_back(es);
    exp_st.push_back(est);
    env_m = env_next(env_m, s);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_count"}, got_s.size(), exp_s.size());
    n = (got_s.size() < exp_s.size()) ? got_s.size() : exp_s.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_sample%0d", tag, i), got_s[i], exp_s[i]);
      check($sformatf("%s_state%0d", tag, i), got_st[i], exp_st[i]);
    end
    got_s.delete(); got_st.delete(); exp_s.delete(); exp_st.delete();
  endtask

  // Drives zeros until the envelope drops below the close level (750 for a
  // threshold of 1000), then holds for i_hold=4 and steps into RELEASE.
  task automatic close_and_hold();
    int n;
    n = 0;
    while (env_next(env_m, 0) >= 750 && n < 400) begin
      send(0, 0, OPEN);
      n++;
    end
    send(0, 0, HOLD);
    repeat (4) send(512, 512, HOLD);
    send(512, 512, RELEASE);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    env_m = 0;
    got_s.delete(); got_st.delete(); exp_s.delete(); exp_st.delete();
  endtask

  initial begin
    rst         = 1'b1;
    i_valid     = 1'b0;
    i_sample    = '0;
    i_threshold = 16'd1000;
    i_hold      = 12'd4;
    i_bypass    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", int'(o_valid), 0);
    check("rst_o_sample", int'(o_sample), 0);
    check("rst_o_state", int'(o_state), CLOSED);
    check("rst_env", int'(dut.env), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Silence below threshold stays muted
    for (int i = 0; i < 8; i++) send((i % 2) ? -200 : 200, 0, CLOSED);
    drain("silence");

    // Attack ramp: 0, 0, 500, ..., 7500, 8000
    for (int k = 1; k <= 18; k++)
      send(8000, (k < 2) ? 0 : (k - 2) * 500, (k < 17) ? ATTACK : OPEN);
    drain("attack");

    // Hold then release down to g = 100 (output = 512*g/256 = 2g)
    close_and_hold();
    for (int j = 1; j <= 156; j++) send(512, 2 * (257 - j), RELEASE);
    drain("hold_rel");

    // Retrigger from g = 100: 3125, 3125, 3625, ... then OPEN at 256
    send(8000, 3125, ATTACK);
    for (int k = 1; k <= 10; k++)
      send(8000, 3125 + 500 * (k - 1), (k < 10) ? ATTACK : OPEN);
    send(8000, 8000, OPEN);
    drain("retrigger");

    // Full release to CLOSED 256 samples after entering RELEASE
    close_and_hold();
    for (int j = 1; j <= 256; j++)
      send(512, 2 * (257 - j), (j < 256) ? RELEASE : CLOSED);
    send(512, 0, CLOSED);
    drain("release");

    // Bypass while closed passes samples through unchanged
    i_bypass = 1'b1;
    send(123, 123, CLOSED);
    send(-456, -456, CLOSED);
    send(999, 999, CLOSED);
    send(-1, -1, CLOSED);
    drain("bypass");
    i_bypass = 1'b0;

    // Most negative input saturates the magnitude; gaps do not decay env
    send(-32768, 0, ATTACK);
    check("env_min_sat", int'(dut.env), 32767);
    repeat (10) @(posedge clk);
    #1;
    check("env_gap_hold", int'(dut.env), 32767);
    send(0, 0, ATTACK);
    check("env_decay", int'(dut.env), 32256);
    send(-1, -1, ATTACK);         // -16 >>> 8 floors to -1
    send(-32768, -4096, ATTACK);  // g = 32
    drain("edge");

    // Reset mid-stream clears outputs at once and drops in-flight samples
    i_sample = 16'sd8000;
    i_valid  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_valid", int'(o_valid), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_o_valid", int'(o_valid), 0);
    check("mid_rst_o_sample", int'(o_sample), 0);
    check("mid_rst_o_state", int'(o_state), CLOSED);
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    env_m = 0;
    got_s.delete(); got_st.delete();
    repeat (3) @(posedge clk);
    #1;
    check("no_ghost_output", got_s.size(), 0);
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    check("lat_cycle1_valid", int'(o_valid), 0);
    @(posedge clk);
    #1;
    check("lat_cycle2_valid", int'(o_valid), 1);
    check("lat_cycle2_state", int'(o_state), ATTACK);
    @(posedge clk);
    #1;
    check("lat_one_shot", int'(o_valid), 0);

    // Threshold 0: opens on the first sample and never closes
    pulse_reset();
    i_threshold = 16'd0;
    for (int k = 1; k <= 24; k++) send(0, 0, (k < 17) ? ATTACK : OPEN);
    drain("thr_zero");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/noise_gate.md
# noise_gate

Upstream noise gate for the guitar chain. It sits directly before the overdrive stage and feeds its 16-bit sample input, so pickup hum and hiss are muted before the gain stage amplifies them. It tracks a peak envelope of the input and drives a gain ramp through an attack/open/hold/release state machine. The gated sample is emitted as a signed 16-bit value after two cycles.

## Interface
- fxp_size, 16, sample width (signed two's complement)
- gain_bits, 8, gain fraction bits; unity gain = 2^gain_bits = 256
- env_shift, 6, envelope decay shift
- hold_bits, 12, width of the hold-length input
- attack_step, 16, gain increment per sample in ATTACK
- release_step, 1, gain decrement per sample in RELEASE

Ports:
- clk  in  1  clock (single clock domain)
- rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  input sample strobe; may be high on consecutive cycles
- i_sample  in  fxp_size  signed input sample
- i_threshold  in  fxp_size  unsigned open threshold (magnitude)
- i_hold  in  hold_bits  hold length in samples
- i_bypass  in  1  1 = output the sample ungated; the FSM keeps running
- o_valid  out  1  output strobe
- o_sample  out  fxp_size  signed gated sample, goes to the overdrive sample input
- o_state  out  3  current FSM state (debug)

## Operation
- Magnitude: abs(i_sample); -32768 saturates to 32767.
- Envelope (unsigned, fxp_size): if abs > env, env = abs; else env = env - (env >> env_shift).
- Thresholds:
  - Open: env >= i_threshold.
  - Close: env < i_threshold - (i_threshold >> 2). This is hysteresis.
- Gain g is unsigned, range 0..256, gain_bits+1 wide. It clamps at both ends.
- FSM states: CLOSED=0, ATTACK=1, OPEN=2, HOLD=3, RELEASE=4. The FSM advances once per stage-1 valid sample.
  - CLOSED: open → ATTACK. g is unchanged on this transition.
  - ATTACK: g += attack_step, clamped to 256. When the result is 256 → OPEN.
  - OPEN: close → HOLD, and the hold counter loads i_hold.
  - HOLD: the checks are evaluated in this priority order:
    - open → OPEN
    - else counter == 0 → RELEASE
    - else counter decrements
  - RELEASE: open → ATTACK, with the ramp continuing from the current g. Otherwise g -= release_step, clamped to 0; when the result is 0 → CLOSED.
  - The window between the close and open thresholds holds the current state.
- Output: o_sample = (s1_sample * g) >>> gain_bits.
  - g is the value before this sample's FSM update.
  - Signed 16×9 product (25 bits); arithmetic shift truncates toward −∞.
  - g = 256 returns the sample exactly.
- Bypass: when i_bypass = 1, o_sample = s1_sample. Gain and state still update.
- Threshold 0: the gate opens on the first sample and never closes.

## Timing
- Stage 1 (cycle of i_valid): register i_sample into s1_sample, update env, set s1_valid.
- Stage 2 (next cycle, when s1_valid): update the FSM and g; register o_sample; o_valid = 1 for one cycle.
- Latency: 2 cycles from i_valid to o_valid. Throughput: one sample per cycle. There is no backpressure.
- Idle cycles (i_valid = 0) change nothing. The envelope decays per sample, not per cycle.
- i_threshold, i_hold and i_bypass are sampled at stage 2. They may change at any time.
- Reset values: env = 0, g = 0, state = CLOSED, hold counter = 0, s1_valid = 0, o_valid = 0, o_sample = 0, o_state = 0.
- Reset mid-operation clears everything immediately. Any in-flight sample is lost and no o_valid is emitted for it.

## Structure
- noise_gate_pkg holds:
  - the gate_state_t enum (3-bit, encodings as above)
  - the GAIN_ONE constant
  - the hysteresis helper function
- Sub-module gate_env_follower: magnitude, saturation and envelope register (stage 1). The FSM, gain ramp and multiply live in noise_gate.

## Test plan
- Reset: assert rst mid-stream → o_valid = 0, o_sample = 0, o_state = 0 in the same cycle. After release, the first output needs a new i_valid plus 2 cycles.
- Silence: threshold 1000, alternating ±200 samples → o_sample = 0 throughout; o_state stays CLOSED.
- Attack ramp: threshold 1000, constant 8000 back-to-back → outputs 0, 0, 500, 1000, …, 7500, 8000. State is OPEN after the 17th sample; the 18th output is 8000.
- Hold/release: from OPEN with i_hold = 4, drive 0 until env < 750 → exactly 5 HOLD samples. Then RELEASE, with g falling by 1 per sample and CLOSED 256 samples later.
- Retrigger: during RELEASE at g = 100, drive 8000 → ATTACK. The next g values are 116, 132, …, clamping at 256 → OPEN.
- Edge cases:
  - input −32768 → env = 32767
  - i_bypass = 1 while CLOSED → o_sample equals the input delayed by 2 cycles
  - i_valid gaps → no envelope decay during the gaps
